// File: rtl/vmx_feeder.sv
// Weight-then-data feeder for a chain of N_PE vector PEs.
// Optional stall counter under `VMX_FEEDER_STALL_CNT_EN.
module vmx_feeder #(
  parameter int VECTOR_BITLEN = 16,
  parameter int N_PE          = 8,
  parameter int LEN_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     cfg_simd,
  input  logic [LEN_BITS-1:0]      cfg_len,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [VECTOR_BITLEN-1:0] s_data,
  output logic [VECTOR_BITLEN-1:0] pe_data,
  output logic [7:0]               pe_is_weight,
  output logic                     pe_simd_mode,
  output logic                     pe_valid,
  output logic                     busy,
`ifdef VMX_FEEDER_STALL_CNT_EN
  output logic [31:0]              stall_cnt,
`endif
  output logic                     done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam int CW = 7;
  localparam logic [CW-1:0] LAST = CW'(N_PE - 1);
  localparam logic [7:0] TOK0 = 8'(8'h80 + N_PE - 1);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LEN_BITS-1:0] len_cnt_q, len_cnt_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic simd_q, simd_d;
  logic [VECTOR_BITLEN-1:0] pe_data_q, pe_data_d;
  logic [7:0] tok_q, tok_d;
  logic pe_valid_q, pe_valid_d;
  logic pe_simd_q, pe_simd_d;
  logic accept;

  assign s_ready = (state_q == LOAD_W) || (state_q == STREAM);
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign accept = s_valid && s_ready;

  assign pe_data = pe_data_q;
  assign pe_is_weight = tok_q;
  assign pe_valid = pe_valid_q;
  assign pe_simd_mode = pe_simd_q;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_cnt_d = len_cnt_q;
    len_d = len_q;
    simd_d = simd_q;
    pe_data_d = accept ? s_data : '0;
    tok_d = '0;
    pe_valid_d = 1'b0;
    pe_simd_d = (state_q != IDLE) ? simd_q : 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          simd_d = cfg_simd;
          len_d = cfg_len;
          cnt_d = '0;
          len_cnt_d = '0;
        end
      end
      LOAD_W: begin
        if (accept) begin
          // first weight carries the highest index: it lands in the last PE
          tok_d = TOK0 - 8'(cnt_q);
          if (cnt_q == LAST) begin
            cnt_d = '0;
            state_d = (len_q != '0) ? STREAM : DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          pe_valid_d = 1'b1;
          len_cnt_d = len_cnt_q + 1'b1;
          if (len_cnt_d == len_q) begin
            state_d = DRAIN;
            cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      len_cnt_q <= '0;
      len_q <= '0;
      simd_q <= 1'b0;
      pe_data_q <= '0;
      tok_q <= '0;
      pe_valid_q <= 1'b0;
      pe_simd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_cnt_q <= len_cnt_d;
      len_q <= len_d;
      simd_q <= simd_d;
      pe_data_q <= pe_data_d;
      tok_q <= tok_d;
      pe_valid_q <= pe_valid_d;
      pe_simd_q <= pe_simd_d;
    end
  end

`ifdef VMX_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  assign stall_cnt = stall_q;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (state_q == STREAM && !s_valid && stall_q != '1) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_vmx_feeder.sv
// Scoreboard bench for vmx_feeder with N_PE = 4.
// Stimulus pushes expected PE outputs; a negedge monitor pops them.
module tb_vmx_feeder;

  logic clk;
  logic rst_n;
  logic start;
  logic cfg_simd;
  logic [15:0] cfg_len;
  logic s_valid;
  logic s_ready;
  logic [15:0] s_data;
  logic [15:0] pe_data;
  logic [7:0] pe_is_weight;
  logic pe_simd_mode;
  logic pe_valid;
  logic busy;
  logic done;
`ifdef VMX_FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  typedef struct packed {
    logic [15:0] d;
    logic [7:0] t;
    logic v;
    logic m;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  vmx_feeder #(
    .VECTOR_BITLEN(16),
    .N_PE(4),
    .LEN_BITS(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .cfg_simd(cfg_simd),
    .cfg_len(cfg_len),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .pe_data(pe_data),
    .pe_is_weight(pe_is_weight),
    .pe_simd_mode(pe_simd_mode),
    .pe_valid(pe_valid),
    .busy(busy),
`ifdef VMX_FEEDER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_seen++;
      if (pe_valid || pe_is_weight != 8'h00) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got %0h/%0h/%0b want none",
                   pe_data, pe_is_weight, pe_valid);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({pe_data, pe_is_weight, pe_valid, pe_simd_mode} !== e) begin
            errors++;
            $display("FAIL pe_out got %0h want %0h",
                     {pe_data, pe_is_weight, pe_valid, pe_simd_mode}, e);
          end
        end
      end else begin
        checks++;
        if (pe_data !== 16'h0) begin
          errors++;
          $display("FAIL bubble_data got %0h want 0", pe_data);
        end
      end
    end
  end

  logic [7:0] wtok [4] = '{8'h83, 8'h82, 8'h81, 8'h80};

  task automatic start_job(input logic simd, input logic [15:0] len);
    @(negedge clk);
    start = 1'b1;
    cfg_simd = simd;
    cfg_len = len;
    @(negedge clk);
    start = 1'b0;
    cfg_simd = ~simd;
    cfg_len = 16'hFFFF;
    chk("busy_after_start", busy, 1);
    chk("ready_in_load", s_ready, 1);
  endtask

  task automatic send(input logic [15:0] d, input logic [7:0] t,
                      input logic v, input logic m);
    int n;
    s_valid = 1'b1;
    s_data = d;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_wait", s_ready, 1);
    sb.push_back('{d: d, t: t, v: v, m: m});
    @(negedge clk);
  endtask

  task automatic send_weights(input logic m);
    for (int i = 0; i < 4; i++) send(16'hA000 + 16'(i), wtok[i], 1'b0, m);
  endtask

  task automatic wait_done();
    s_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("done_at_%0d", k), done, (k == 5) ? 1 : 0);
      if (k == 6) chk("busy_end", busy, 0);
      if (k < 5) chk("ready_drain", s_ready, 0);
      if (k < 6) @(negedge clk);
    end
  endtask

  int done_before;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_simd = 1'b0;
    cfg_len = 16'h0;
    s_valid = 1'b0;
    s_data = 16'h0;
    #12;
    chk("rst_pe_data", pe_data, 0);
    chk("rst_tok", pe_is_weight, 0);
    chk("rst_misc", {pe_simd_mode, pe_valid, busy, done, s_ready}, 0);
`ifdef VMX_FEEDER_STALL_CNT_EN
    chk("rst_stall", stall_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    start_job(1'b1, 16'd3);
    send_weights(1'b1);
    send(16'h0102, 8'h00, 1'b1, 1'b1);
    send(16'h0304, 8'h00, 1'b1, 1'b1);
    send(16'h0506, 8'h00, 1'b1, 1'b1);
    wait_done();
`ifdef VMX_FEEDER_STALL_CNT_EN
    chk("stall_a", stall_cnt, 0);
`endif

    start_job(1'b0, 16'd3);
    send_weights(1'b0);
    send(16'h0102, 8'h00, 1'b1, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    send(16'h0304, 8'h00, 1'b1, 1'b0);
    send(16'h0506, 8'h00, 1'b1, 1'b0);
    wait_done();
`ifdef VMX_FEEDER_STALL_CNT_EN
    chk("stall_bubble", stall_cnt, 2);
`endif

    start_job(1'b0, 16'd0);
    send_weights(1'b0);
    wait_done();

    start_job(1'b1, 16'd3);
    send_weights(1'b1);
    send(16'h1111, 8'h00, 1'b1, 1'b1);
    start = 1'b1;
    cfg_simd = 1'b0;
    cfg_len = 16'd7;
    send(16'h2222, 8'h00, 1'b1, 1'b1);
    start = 1'b0;
    send(16'h3333, 8'h00, 1'b1, 1'b1);
    wait_done();

    start_job(1'b1, 16'd3);
    send(16'hA000, 8'h83, 1'b0, 1'b1);
    send(16'hA001, 8'h82, 1'b0, 1'b1);
    s_valid = 1'b0;
    done_before = done_seen;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pe_data", pe_data, 0);
    chk("arst_tok", pe_is_weight, 0);
    chk("arst_misc", {pe_simd_mode, pe_valid, busy, done, s_ready}, 0);
    chk("arst_sb_empty", sb.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("arst_no_done", done_seen, done_before);
    chk("arst_idle", busy, 0);

    start_job(1'b0, 16'd2);
    send_weights(1'b0);
    send(16'h4444, 8'h00, 1'b1, 1'b0);
    send(16'h5555, 8'h00, 1'b1, 1'b0);
    wait_done();

    chk("sb_drained", sb.size(), 0);
    chk("done_total", done_seen, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
